// File: rtl/sum_accumulator16_if.sv
// Operand/result handshake bundle for sum_accumulator16.
// The master drives operands and the result ready; the slave is the accumulator.
interface sum_accumulator16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/sum_accumulator16.sv
// Packet accumulator: sums signed 16-bit operands up to in_last, then presents
// the wrapped sum, saturating beat count and sticky signed-overflow flag.
module sum_accumulator16 (
  input  logic               clk,
  input  logic               rst_n,
  sum_accumulator16_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] acc_r, acc_s;
  logic [7:0]  count_r, count_s;
  logic        ovf_r, ovf_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [15:0] sum_s;
  logic        ovf_step_s;
  logic        xfer_s;

  // 16-bit carry-lookahead sum: 4-bit groups with a lookahead over group carries.
  function automatic logic [15:0] cla16_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [2:0]  gg;
    logic [2:0]  gp;
    g    = a & b;
    p    = a ^ b;
    c    = 16'd0;
    c[0] = cin;
    for (int k = 0; k < 3; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
    c[4]  = gg[0] | (gp[0] & c[0]);
    c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
    c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    return p ^ c;
  endfunction

  assign xfer_s     = bus.in_valid & in_ready_r;
  assign sum_s      = cla16_sum(acc_r, bus.in_data, 1'b0);
  assign ovf_step_s = (acc_r[15] == bus.in_data[15]) && (sum_s[15] != acc_r[15]);

  // Next-state and datapath update; holding is the default in every state.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    count_s = count_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (xfer_s) begin
          acc_s   = sum_s;
          count_s = (count_r == 8'd255) ? 8'd255 : count_r + 8'd1;
          ovf_s   = ovf_r | ovf_step_s;
          state_s = bus.in_last ? DONE : ACCUM;
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          acc_s   = 16'd0;
          count_s = 8'd0;
          ovf_s   = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        acc_s   = 16'd0;
        count_s = 8'd0;
        ovf_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= 16'd0;
      count_r     <= 8'd0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      count_r     <= count_s;
      ovf_r       <= ovf_s;
      in_ready_r  <= (state_s != DONE);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = acc_r;
  assign bus.out_count = count_r;
  assign bus.out_ovf   = ovf_r;

endmodule

// File: tb/tb_sum_accumulator16.sv
// Self-checking bench for sum_accumulator16: directed packets plus randomized
// traffic scored against an integer-arithmetic packet model.
module tb_sum_accumulator16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sum_accumulator16_if ifc ();

  sum_accumulator16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int packets  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model, evaluated mid-cycle: predicts what the next edge does.
  logic [15:0] m_acc  = 16'd0;
  int          m_cnt  = 0;
  logic        m_ovf  = 1'b0;
  bit          m_done = 1'b0;

  initial begin
    int s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_sum", ifc.out_sum, 0);
        chk("rst_out_count", ifc.out_count, 0);
        chk("rst_out_ovf", ifc.out_ovf, 0);
        m_acc  = 16'd0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
      end else begin
        chk("in_ready", ifc.in_ready, !m_done);
        chk("out_valid", ifc.out_valid, m_done);
        if (m_done) begin
          chk("out_sum", ifc.out_sum, m_acc);
          chk("out_count", ifc.out_count, m_cnt);
          chk("out_ovf", ifc.out_ovf, m_ovf);
          if (ifc.out_ready) begin
            m_acc  = 16'd0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
            packets++;
          end
        end else if (ifc.in_valid) begin
          s = int'($signed(m_acc)) + int'($signed(ifc.in_data));
          if (s > 32767 || s < -32768) m_ovf = 1'b1;
          m_acc = 16'(s);
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          if (ifc.in_last) m_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    bit took;
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = last;
    do begin
      took = ifc.in_ready;
      tick();
      n++;
    end while (!took && n < 1000);
    if (!took) chk("send_timeout", 0, 1);
    ifc.in_valid = 1'b0;
    ifc.in_data  = 16'($urandom);
    ifc.in_last  = 1'($urandom);
  endtask

  task automatic expect_result(input logic [15:0] sum, input logic [7:0] cnt,
                               input logic ovf, input int hold);
    chk("dir_out_valid", ifc.out_valid, 1);
    chk("dir_out_sum", ifc.out_sum, sum);
    chk("dir_out_count", ifc.out_count, cnt);
    chk("dir_out_ovf", ifc.out_ovf, ovf);
    ifc.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 16'($urandom);
      ifc.in_last  = 1'($urandom);
      tick();
      chk("hold_out_valid", ifc.out_valid, 1);
      chk("hold_out_sum", ifc.out_sum, sum);
      chk("hold_in_ready", ifc.in_ready, 0);
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk("release_out_valid", ifc.out_valid, 0);
    chk("release_in_ready", ifc.in_ready, 1);
    chk("release_out_sum", ifc.out_sum, 0);
  endtask

  initial begin
    int sel;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = 16'd0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Multi-beat packet
    ifc.out_ready = 1'b1;
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'd3, 1'b1);
    expect_result(16'd6, 8'd3, 1'b0, 0);

    // Signed overflow, then a clean packet
    send(16'h7FFF, 1'b0);
    send(16'h0001, 1'b1);
    expect_result(16'h8000, 8'd2, 1'b1, 0);
    send(16'd5, 1'b1);
    expect_result(16'd5, 8'd1, 1'b0, 0);

    // Single beat under backpressure
    send(16'hFFFE, 1'b1);
    expect_result(16'hFFFE, 8'd1, 1'b0, 4);

    // Count saturation
    for (int i = 0; i < 300; i++) send(16'd1, (i == 299) ? 1'b1 : 1'b0);
    expect_result(16'd300, 8'd255, 1'b0, 0);

    // Reset mid-packet
    send(16'd10, 1'b0);
    send(16'd20, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", ifc.out_valid, 0);
    rst_n = 1'b1;
    send(16'd7, 1'b1);
    expect_result(16'd7, 8'd1, 1'b0, 0);

    // Randomized traffic, scored by the model
    packets = 0;
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       ifc.in_data = 16'h7FFF;
        1:       ifc.in_data = 16'h8000;
        2:       ifc.in_data = 16'hFFFF;
        3:       ifc.in_data = 16'h4000;
        default: ifc.in_data = 16'($urandom);
      endcase
      ifc.in_valid  = ($urandom_range(0, 9) < 7);
      ifc.in_last   = ($urandom_range(0, 5) == 0);
      ifc.out_ready = 1'($urandom);
      rst_n         = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (4) tick();
    chk("random_packets_seen", (packets > 50), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
